// File: rtl/ensemble_vote_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_vote_collector_pkg
// Description : Shared constants, FSM encoding and ID-slice helper for the
//               ensemble majority-vote collector.
// Revision    : 1.0 - initial release
// ============================================================================
package ensemble_vote_collector_pkg;

    localparam int ID_W = 5;
    localparam logic [ID_W-1:0] NO_DECISION = 5'h1F;

    // Upper bound on ensemble size; the helper works on a bus padded to this
    // width so one function serves every legal NUM_NETS.
    localparam int MAX_NETS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_TALLY   = 3'd2,
        ST_ARGMAX  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Extract net k's ID from a packed ID bus (net k at bits [5k+4:5k]).
    function automatic logic [ID_W-1:0] net_id(
        input logic [MAX_NETS*ID_W-1:0] bus,
        input int                       k
    );
        return bus[k*ID_W +: ID_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ensemble_vote_collector_ready_edge_capture.sv
`default_nettype none
// ============================================================================
// Module      : ready_edge_capture
// Description : Per-net infer_ready rising-edge detector, winner ID latch,
//               reported flag and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ready_edge_capture
    import ensemble_vote_collector_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_infer_ready,
    input  logic [ID_W-1:0] i_winner_id,
    input  logic            i_clear,
    input  logic            i_capture_en,
    output logic            o_reported,
    output logic            o_capture,
    output logic [ID_W-1:0] o_id,
    output logic            o_overrun
);

    logic            r_ir_d;
    logic            r_reported;
    logic [ID_W-1:0] r_id;
    logic            r_overrun;

    logic            w_edge;
    logic            w_capture;
    logic            w_flag;

    assign w_edge    = i_infer_ready & ~r_ir_d;
    assign w_capture = w_edge & i_capture_en & ~r_reported;
    // Any edge that is not accepted is an overrun, except edges coinciding
    // with the clear pulse, which are silently discarded.
    assign w_flag    = w_edge & ~i_clear & ~w_capture;

    // Edge-detect history, ID latch, reported mask bit and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_d     <= 1'b0;
            r_reported <= 1'b0;
            r_id       <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_ir_d <= i_infer_ready;
            if (i_clear) begin
                r_reported <= 1'b0;
                r_overrun  <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_reported <= 1'b1;
                    r_id       <= i_winner_id;
                end
                if (w_flag) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_reported = r_reported;
    assign o_capture  = w_capture;
    assign o_id       = r_id;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: rtl/ensemble_vote_collector.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_vote_collector
// Description : Collects winner IDs from NUM_NETS ensemble members, tallies
//               them serially and reports the majority class (lowest ID wins
//               ties) with a one-cycle final_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ensemble_vote_collector
    import ensemble_vote_collector_pkg::*;
#(
    parameter int NUM_NETS    = 20,
    parameter int NUM_CLASSES = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_start,
    input  logic [NUM_NETS*ID_W-1:0] winner_ID_bus,
    input  logic [NUM_NETS-1:0]      infer_ready_bus,
    output logic [ID_W-1:0]          ensemble_ID,
    output logic [ID_W-1:0]          ensemble_votes,
    output logic                     final_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int              c_PAD_W       = (MAX_NETS - NUM_NETS) * ID_W;
    localparam logic [ID_W-1:0] c_LAST_NET    = ID_W'(NUM_NETS - 1);
    localparam logic [ID_W-1:0] c_LAST_CLASS  = ID_W'(NUM_CLASSES - 1);
    localparam logic [ID_W-1:0] c_CLASS_LIMIT = ID_W'(NUM_CLASSES);

    state_t                r_state;
    state_t                w_state_next;

    logic [MAX_NETS*ID_W-1:0] w_win_ext;
    logic [NUM_NETS-1:0]   w_reported;
    logic [NUM_NETS-1:0]   w_capture;
    logic [NUM_NETS-1:0]   w_overrun;
    logic [NUM_NETS-1:0]   w_mask_next;
    logic [ID_W-1:0]       w_id [NUM_NETS];
    logic                  w_capture_en;
    logic [ID_W-1:0]       w_tally_id;

    logic [ID_W-1:0]       r_idx;
    logic [ID_W-1:0]       r_cnt [NUM_CLASSES];
    logic [ID_W-1:0]       r_best_id;
    logic [ID_W-1:0]       r_best_cnt;
    logic [ID_W-1:0]       r_ensemble_id;
    logic [ID_W-1:0]       r_ensemble_votes;
    logic                  r_final_valid;

    assign w_win_ext    = {{c_PAD_W{1'b0}}, winner_ID_bus};
    // Reports in the sample_start cycle are discarded by the restart.
    assign w_capture_en = (r_state == ST_COLLECT) && !sample_start;
    // Include this cycle's captures so TALLY starts right after the last one.
    assign w_mask_next  = w_reported | w_capture;

    generate
        for (genvar k = 0; k < NUM_NETS; k++) begin : g_net
            logic [ID_W-1:0] w_win;
            assign w_win = net_id(w_win_ext, k);

            ready_edge_capture u_capture (
                .clk          (clk),
                .rst          (rst),
                .i_infer_ready(infer_ready_bus[k]),
                .i_winner_id  (w_win),
                .i_clear      (sample_start),
                .i_capture_en (w_capture_en),
                .o_reported   (w_reported[k]),
                .o_capture    (w_capture[k]),
                .o_id         (w_id[k]),
                .o_overrun    (w_overrun[k])
            );
        end
    endgenerate

    assign w_tally_id = w_id[r_idx];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; sample_start restarts collection from any state.
    always_comb begin
        w_state_next = r_state;
        if (sample_start) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_IDLE;
                ST_COLLECT: if (&w_mask_next) w_state_next = ST_TALLY;
                ST_TALLY:   if (r_idx == c_LAST_NET) w_state_next = ST_ARGMAX;
                ST_ARGMAX:  if (r_idx == c_LAST_CLASS) w_state_next = ST_DONE;
                ST_DONE:    w_state_next = ST_IDLE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Serial tally, serial argmax and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx            <= '0;
            r_best_id        <= NO_DECISION;
            r_best_cnt       <= '0;
            r_ensemble_id    <= NO_DECISION;
            r_ensemble_votes <= '0;
            r_final_valid    <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_final_valid <= 1'b0;
            if (sample_start) begin
                r_idx      <= '0;
                r_best_id  <= NO_DECISION;
                r_best_cnt <= '0;
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    r_cnt[c] <= '0;
                end
            end else begin
                case (r_state)
                    ST_COLLECT: begin
                        r_idx <= '0;
                    end
                    ST_TALLY: begin
                        // Out-of-range IDs are discarded votes.
                        if (w_tally_id < c_CLASS_LIMIT) begin
                            r_cnt[w_tally_id] <= r_cnt[w_tally_id] + 5'd1;
                        end
                        r_idx <= (r_idx == c_LAST_NET) ? '0 : r_idx + 5'd1;
                    end
                    ST_ARGMAX: begin
                        // Strictly greater keeps the lowest class on ties and
                        // leaves NO_DECISION when every count is zero.
                        if (r_cnt[r_idx] > r_best_cnt) begin
                            r_best_id  <= r_idx;
                            r_best_cnt <= r_cnt[r_idx];
                        end
                        r_idx <= r_idx + 5'd1;
                    end
                    ST_DONE: begin
                        r_ensemble_id    <= r_best_id;
                        r_ensemble_votes <= r_best_cnt;
                        r_final_valid    <= 1'b1;
                    end
                    default: begin
                        r_idx <= r_idx;
                    end
                endcase
            end
        end
    end

    assign ensemble_ID    = r_ensemble_id;
    assign ensemble_votes = r_ensemble_votes;
    assign final_valid    = r_final_valid;
    assign busy           = (r_state != ST_IDLE);
    assign overrun        = |w_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ensemble_vote_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ensemble_vote_collector
// Description : Directed self-checking bench for ensemble_vote_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ensemble_vote_collector;

    localparam int N = 20;

    logic           clk;
    logic           rst;
    logic           sample_start;
    logic [N*5-1:0] winner_ID_bus;
    logic [N-1:0]   infer_ready_bus;
    logic [4:0]     ensemble_ID;
    logic [4:0]     ensemble_votes;
    logic           final_valid;
    logic           busy;
    logic           overrun;

    int n_checks = 0;
    int n_fail   = 0;

    ensemble_vote_collector #(.NUM_NETS(20), .NUM_CLASSES(18)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_start   (sample_start),
        .winner_ID_bus  (winner_ID_bus),
        .infer_ready_bus(infer_ready_bus),
        .ensemble_ID    (ensemble_ID),
        .ensemble_votes (ensemble_votes),
        .final_valid    (final_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_sample();
        @(negedge clk) sample_start = 1'b1;
        @(negedge clk) sample_start = 1'b0;
    endtask

    // Count rising edges until final_valid is seen (sampled 1 after the edge).
    task automatic wait_final(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (final_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (ensemble_ID !== 5'h1F || ensemble_votes !== 5'd0 || final_valid !== 1'b0
            || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: id=%h votes=%0d fv=%b busy=%b ovr=%b, want 1f 0 0 0 0",
                     ensemble_ID, ensemble_votes, final_valid, busy, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ensemble_ID !== 5'h1F) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b id=%h, want 0 1f", busy, ensemble_ID);
        end
    endtask

    task automatic test_unanimous();
        int n;
        bit ok;
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = 5'd7;
        start_sample();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: busy=%b, want 1", busy);
        end
        for (int k = 0; k < N; k++) begin
            infer_ready_bus[k] = 1'b1;
            @(negedge clk);
        end
        wait_final(n, ok);
        n_checks++;
        if (!ok || n != 39) begin
            n_fail++;
            $display("FAIL unanimous_latency: seen=%b cycles=%0d, want 1 39", ok, n);
        end
        n_checks++;
        if (ensemble_ID !== 5'd7 || ensemble_votes !== 5'd20) begin
            n_fail++;
            $display("FAIL unanimous_result: id=%0d votes=%0d, want 7 20", ensemble_ID, ensemble_votes);
        end
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL unanimous_flags: busy=%b ovr=%b, want 0 0", busy, overrun);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (final_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL final_valid_width: fv=%b, want 0", final_valid);
        end
        @(negedge clk) infer_ready_bus = '0;
    endtask

    task automatic test_tie_break();
        int n;
        bit ok;
        for (int k = 0; k < N; k++)
            winner_ID_bus[k*5 +: 5] = (k < 8) ? 5'd5 : (k < 16) ? 5'd3 : 5'd9;
        start_sample();
        infer_ready_bus = '1;
        wait_final(n, ok);
        n_checks++;
        if (!ok || ensemble_ID !== 5'd3 || ensemble_votes !== 5'd8) begin
            n_fail++;
            $display("FAIL tie_break: seen=%b id=%0d votes=%0d, want 1 3 8", ok, ensemble_ID, ensemble_votes);
        end
        @(negedge clk) infer_ready_bus = '0;
    endtask

    task automatic test_invalid();
        int n;
        bit ok;
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = (k >= 18) ? 5'd4 : 5'd25;
        start_sample();
        infer_ready_bus = '1;
        wait_final(n, ok);
        n_checks++;
        if (!ok || ensemble_ID !== 5'd4 || ensemble_votes !== 5'd2) begin
            n_fail++;
            $display("FAIL invalid_mix: seen=%b id=%0d votes=%0d, want 1 4 2", ok, ensemble_ID, ensemble_votes);
        end
        @(negedge clk) infer_ready_bus = '0;
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = 5'd25;
        start_sample();
        infer_ready_bus = '1;
        wait_final(n, ok);
        n_checks++;
        if (!ok || ensemble_ID !== 5'h1F || ensemble_votes !== 5'd0) begin
            n_fail++;
            $display("FAIL all_invalid: seen=%b id=%h votes=%0d, want 1 1f 0", ok, ensemble_ID, ensemble_votes);
        end
        @(negedge clk) infer_ready_bus = '0;
    endtask

    task automatic test_overrun();
        int n;
        bit ok;
        // Clean reference: IDs k%3 give counts 7,7,6 -> class 0 with 7.
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = 5'(k % 3);
        start_sample();
        infer_ready_bus = '1;
        wait_final(n, ok);
        n_checks++;
        if (!ok || ensemble_ID !== 5'd0 || ensemble_votes !== 5'd7 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_run: seen=%b id=%0d votes=%0d ovr=%b, want 1 0 7 0",
                     ok, ensemble_ID, ensemble_votes, overrun);
        end
        @(negedge clk) infer_ready_bus = '0;
        // Dirty run: duplicate from net 2 carries a different ID.
        start_sample();
        infer_ready_bus[2] = 1'b1;
        @(negedge clk);
        infer_ready_bus[2] = 1'b0;
        winner_ID_bus[2*5 +: 5] = 5'd1;
        @(negedge clk);
        infer_ready_bus[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL duplicate_overrun: ovr=%b, want 1", overrun);
        end
        infer_ready_bus = 20'hFFFFE;
        @(negedge clk);
        infer_ready_bus[0] = 1'b1;
        @(negedge clk);
        // Now in TALLY: late re-report from net 0 with a different ID.
        infer_ready_bus[0] = 1'b0;
        winner_ID_bus[0 +: 5] = 5'd2;
        @(negedge clk);
        infer_ready_bus[0] = 1'b1;
        wait_final(n, ok);
        n_checks++;
        if (!ok || ensemble_ID !== 5'd0 || ensemble_votes !== 5'd7 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL dirty_run: seen=%b id=%0d votes=%0d ovr=%b, want 1 0 7 1",
                     ok, ensemble_ID, ensemble_votes, overrun);
        end
        @(negedge clk) infer_ready_bus = '0;
    endtask

    task automatic test_abort();
        int pulses = 0;
        logic [4:0] id_seen = 5'h00;
        logic [4:0] votes_seen = 5'h00;
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = 5'd1;
        start_sample();
        infer_ready_bus = 20'h003FF;
        @(negedge clk);
        infer_ready_bus = '0;
        @(negedge clk);
        sample_start = 1'b1;
        @(negedge clk);
        sample_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags: busy=%b ovr=%b, want 1 0", busy, overrun);
        end
        infer_ready_bus = '1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (final_valid) begin
                pulses++;
                id_seen    = ensemble_ID;
                votes_seen = ensemble_votes;
            end
        end
        n_checks++;
        if (pulses != 1 || id_seen !== 5'd1 || votes_seen !== 5'd20) begin
            n_fail++;
            $display("FAIL abort_result: pulses=%0d id=%0d votes=%0d, want 1 1 20", pulses, id_seen, votes_seen);
        end
        @(negedge clk) infer_ready_bus = '0;
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        for (int k = 0; k < N; k++) winner_ID_bus[k*5 +: 5] = 5'd6;
        start_sample();
        infer_ready_bus = '1;
        @(negedge clk);
        infer_ready_bus[5] = 1'b0;
        @(negedge clk);
        infer_ready_bus[5] = 1'b1;
        repeat (26) @(posedge clk);
        #3;
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || final_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: ovr=%b busy=%b fv=%b, want 1 1 0", overrun, busy, final_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ensemble_ID !== 5'h1F || ensemble_votes !== 5'd0 || busy !== 1'b0
            || overrun !== 1'b0 || final_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: id=%h votes=%0d busy=%b ovr=%b fv=%b, want 1f 0 0 0 0",
                     ensemble_ID, ensemble_votes, busy, overrun, final_valid);
        end
        @(negedge clk);
        infer_ready_bus = '0;
        n_checks++;
        if (ensemble_ID !== 5'h1F || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: id=%h busy=%b ovr=%b, want 1f 0 0", ensemble_ID, busy, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (final_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || ensemble_ID !== 5'h1F) begin
            n_fail++;
            $display("FAIL no_partial_result: pulses=%0d id=%h, want 0 1f", pulses, ensemble_ID);
        end
    endtask

    initial begin
        rst             = 1'b1;
        sample_start    = 1'b0;
        winner_ID_bus   = '0;
        infer_ready_bus = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_unanimous();
        test_tie_break();
        test_invalid();
        test_overrun();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
